// File: rtl/div_pkg.sv
// Shared types and helpers for the divide-by-(2^K - 1) datapath.
package div_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int DEF_K   = 8;
    localparam int DIVISOR = (1 << DEF_K) - 1;

    function automatic int divisor_of(input int k);
        return (1 << k) - 1;
    endfunction

    // Minimum bits to hold values 0..n-1, never less than one.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++)
            if ((1 << i) < n) w = i + 1;
        return w;
    endfunction

endpackage

// File: rtl/div_pow2m1_step.sv
// One restoring division step against D = 2^K - 1: shift in a dividend bit, subtract if it fits.
module div_pow2m1_step
    import div_pkg::*;
#(
    parameter int K = 8
) (
    input  logic [K:0] i_p,
    input  logic       i_bit,
    output logic [K:0] o_p,
    output logic       o_qbit
);

    localparam logic [K+1:0] D_WIDE = (K+2)'(divisor_of(K));
    localparam logic [K:0]   D      = (K+1)'(divisor_of(K));

    logic [K+1:0] w_shift;
    logic [K:0]   w_sub;
    logic         w_ge;

    // Full-width compare keeps the spare top bit of P meaningful even though it stays zero.
    assign w_shift = {i_p, i_bit};
    assign w_ge    = (w_shift >= D_WIDE);
    assign w_sub   = w_shift[K:0] - D;
    assign o_p     = w_ge ? w_sub : w_shift[K:0];
    assign o_qbit  = w_ge;

endmodule

// File: rtl/div_pow2m1_seq.sv
// Iterative unsigned divider by 2^K - 1, one quotient bit per cycle with start/busy/done.
module div_pow2m1_seq
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int K     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [K-1:0]     r
);

    localparam int            CW       = clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_x;
    logic [K:0]       r_p;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [K-1:0]     r_r;
    logic [K:0]       w_p_nxt;
    logic             w_qbit;
    logic             w_accept;
    logic [WIDTH-1:0] w_x_nxt;

    div_pow2m1_step #(.K(K)) u_step (
        .i_p    (r_p),
        .i_bit  (r_x[WIDTH-1]),
        .o_p    (w_p_nxt),
        .o_qbit (w_qbit)
    );

    // Dividend shifts out of the top while quotient bits fill in from the bottom.
    assign w_x_nxt  = {r_x[WIDTH-2:0], w_qbit};
    assign w_accept = start && (r_state != RUN);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (r_cnt == '0) w_state_nxt = DONE;
            DONE:    w_state_nxt = start ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x   <= '0;
            r_p   <= '0;
            r_cnt <= '0;
            r_q   <= '0;
            r_r   <= '0;
        end else if (w_accept) begin
            r_x   <= x;
            r_p   <= '0;
            r_cnt <= CNT_INIT;
        end else if (r_state == RUN) begin
            r_x <= w_x_nxt;
            r_p <= w_p_nxt;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end else begin
                r_q <= w_x_nxt;
                r_r <= w_p_nxt[K-1:0];
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign q    = r_q;
    assign r    = r_r;

endmodule

// File: tb/tb_div_pow2m1_seq.sv
// Directed and random checks of div_pow2m1_seq in the 32/8 and 16/4 configurations.
module tb_div_pow2m1_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0;
    logic [31:0] x_a = '0;
    logic        busy_a, done_a;
    logic [31:0] q_a;
    logic [7:0]  r_a;
    logic        start_b = 1'b0;
    logic [15:0] x_b = '0;
    logic        busy_b, done_b;
    logic [15:0] q_b;
    logic [3:0]  r_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    div_pow2m1_seq #(.WIDTH(32), .K(8)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .x(x_a),
        .busy(busy_a), .done(done_a), .q(q_a), .r(r_a)
    );

    div_pow2m1_seq #(.WIDTH(16), .K(4)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .x(x_b),
        .busy(busy_b), .done(done_b), .q(q_b), .r(r_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Run one op on instance sel (0: 32/8, 1: 16/4); checks latency, pulse width, q and r.
    task automatic op(input int sel, input logic [31:0] xv, input logic [31:0] eq,
                      input logic [31:0] er, input string tag);
        int n;
        int w;
        logic d;
        w = sel ? 16 : 32;
        @(negedge clk);
        if (sel) begin start_b = 1'b1; x_b = xv[15:0]; end
        else     begin start_a = 1'b1; x_a = xv;       end
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        chk({tag, "_busy"}, sel ? busy_b : busy_a, 1);
        n = 0;
        d = 1'b0;
        while (!d && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            d = sel ? done_b : done_a;
        end
        chk({tag, "_lat"}, n, w);
        chk({tag, "_q"}, sel ? {16'h0, q_b} : q_a, eq);
        chk({tag, "_r"}, sel ? {28'h0, r_b} : {24'h0, r_a}, er);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, sel ? done_b : done_a, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("excl_a", done_a & busy_a, 0);
            chk("excl_b", done_b & busy_b, 0);
            chk("rrng_a", r_a < 8'd255, 1);
            chk("rrng_b", r_b < 4'd15, 1);
        end
    end

    initial begin
        logic [31:0] xv;
        int lowb;
        int dcyc [2];
        int nd;
        logic seen;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_q", q_a, 0);
        chk("rst_r", r_a, 0);
        @(negedge clk);
        rst = 1'b0;

        op(0, 2550, 10, 0, "a2550");
        op(0, 8160, 32, 0, "a8160");
        op(0, 32640, 128, 0, "a32640");
        op(0, 4335, 17, 0, "a4335");
        op(0, 4336, 17, 1, "a4336");
        op(0, 254, 0, 254, "a254");
        op(0, 255, 1, 0, "a255");
        op(0, 0, 0, 0, "a0");
        op(0, 32'hFFFFFFFF, 16843009, 0, "amax");

        // Back-to-back with start held high and x wiggled during RUN.
        @(negedge clk);
        start_a = 1'b1;
        x_a = 1000;
        @(posedge clk);
        #1;
        lowb = 0;
        nd = 0;
        for (int c = 1; c <= 66; c++) begin
            @(posedge clk);
            #1;
            if (c == 5)  x_a = 5100;
            if (c == 40) x_a = 0;
            if (done_a) begin
                if (nd < 2) dcyc[nd] = c;
                nd++;
                if (nd == 1) begin
                    chk("b2b_q1", q_a, 3);
                    chk("b2b_r1", r_a, 235);
                end else begin
                    chk("b2b_q2", q_a, 20);
                    chk("b2b_r2", r_a, 0);
                    start_a = 1'b0;
                end
            end
            if (!busy_a && c <= 65) lowb++;
        end
        chk("b2b_ndone", nd, 2);
        chk("b2b_first", dcyc[0], 32);
        chk("b2b_period", dcyc[1] - dcyc[0], 33);
        chk("b2b_lowbusy", lowb, 2);
        chk("b2b_idle", busy_a, 0);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        start_a = 1'b1;
        x_a = 12345;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("mrst_busy", busy_a, 0);
        chk("mrst_done", done_a, 0);
        chk("mrst_q", q_a, 0);
        chk("mrst_r", r_a, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done_a || busy_a) seen = 1'b1;
        end
        chk("mrst_quiet", seen, 0);
        op(0, 12345, 48, 105, "a12345");

        op(1, 100, 6, 10, "b100");
        op(1, 16'hFFFF, 4369, 0, "bmax");
        op(1, 15, 1, 0, "b15");
        op(1, 14, 0, 14, "b14");

        for (int i = 0; i < 1000; i++) begin
            xv = $urandom;
            op(0, xv, xv / 255, xv % 255, "ra");
        end
        for (int i = 0; i < 1000; i++) begin
            xv = $urandom & 32'h0000FFFF;
            op(1, xv, xv / 15, xv % 15, "rb");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
